// File: rtl/alu_defs.sv
// Shared ALU definitions: opcode map, error byte, controller state encoding.
package alu_defs;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

    localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hFF;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    // True for every opcode the external ALU implements.
    function automatic logic op_is_valid(input logic [5:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Idle-cycle counter: saturates at TIMEOUT_CYCLES-1 and flags expiry there.
module idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] count_r;
    logic         at_last_s;

    assign at_last_s = (count_r == LAST);
    assign expired   = enable & at_last_s;

    // Count enabled idle cycles; clear wins, and the count holds at LAST so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && !at_last_s) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frames three UART bytes (A, B, opcode) into an external ALU and sends the result back.
module uart_alu_ctrl
    import alu_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  ERR_BYTE       = ERR_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [5:0] alu_op,
    input  logic [7:0] alu_result,
    output logic       busy,
    output logic       err,
    output logic       timeout,
    output logic       overrun
);

    state_t     state_r, state_next;
    logic       latch_a_s, latch_b_s, latch_op_s;
    logic       overrun_s, timeout_s;
    logic       timer_clear_s, timer_en_s, expired_s;
    logic       tx_start_r, err_r, timeout_r, overrun_r, busy_r;
    logic [7:0] tx_data_r, alu_a_r, alu_b_r;
    logic [5:0] alu_op_r;

    assign timer_clear_s = rx_done | (state_next != state_r);
    assign timer_en_s    = (state_r == ST_WAIT_B) | (state_r == ST_WAIT_OP);

    idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (expired_s)
    );

    // Next-state and byte-latch decode; a received byte beats a simultaneous timeout.
    always_comb begin
        state_next = state_r;
        latch_a_s  = 1'b0;
        latch_b_s  = 1'b0;
        latch_op_s = 1'b0;
        overrun_s  = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            ST_WAIT_A: begin
                if (rx_done) begin
                    latch_a_s  = 1'b1;
                    state_next = ST_WAIT_B;
                end else begin
                    state_next = ST_WAIT_A;
                end
            end
            ST_WAIT_B: begin
                if (rx_done) begin
                    latch_b_s  = 1'b1;
                    state_next = ST_WAIT_OP;
                end else if (expired_s) begin
                    timeout_s  = 1'b1;
                    state_next = ST_WAIT_A;
                end else begin
                    state_next = ST_WAIT_B;
                end
            end
            ST_WAIT_OP: begin
                if (rx_done) begin
                    latch_op_s = 1'b1;
                    state_next = ST_EXEC;
                end else if (expired_s) begin
                    timeout_s  = 1'b1;
                    state_next = ST_WAIT_A;
                end else begin
                    state_next = ST_WAIT_OP;
                end
            end
            ST_EXEC: begin
                overrun_s  = rx_done;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                overrun_s  = rx_done;
                state_next = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                overrun_s = rx_done;
                if (tx_done) begin
                    state_next = ST_WAIT_A;
                end else begin
                    state_next = ST_WAIT_TX;
                end
            end
            default: begin
                state_next = ST_WAIT_A;
            end
        endcase
    end

    // State, operand registers and registered event/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_WAIT_A;
            alu_a_r    <= 8'h00;
            alu_b_r    <= 8'h00;
            alu_op_r   <= 6'h00;
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            err_r      <= 1'b0;
            timeout_r  <= 1'b0;
            overrun_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next;
            alu_a_r    <= latch_a_s  ? rx_data      : alu_a_r;
            alu_b_r    <= latch_b_s  ? rx_data      : alu_b_r;
            alu_op_r   <= latch_op_s ? rx_data[5:0] : alu_op_r;
            if (state_r == ST_EXEC) begin
                tx_data_r <= op_is_valid(alu_op_r) ? alu_result : ERR_BYTE;
            end else begin
                tx_data_r <= tx_data_r;
            end
            tx_start_r <= (state_r == ST_EXEC);
            err_r      <= (state_r == ST_EXEC) && !op_is_valid(alu_op_r);
            timeout_r  <= timeout_s;
            overrun_r  <= overrun_s;
            busy_r     <= (state_next != ST_WAIT_A);
        end
    end

    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;
    assign alu_a    = alu_a_r;
    assign alu_b    = alu_b_r;
    assign alu_op   = alu_op_r;
    assign busy     = busy_r;
    assign err      = err_r;
    assign timeout  = timeout_r;
    assign overrun  = overrun_r;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with a reference ALU on the operand outputs.
module tb_uart_alu_ctrl;
    import alu_defs::*;

    logic       clk;
    logic       rst_n;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;
    logic       busy;
    logic       err;
    logic       timeout;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    uart_alu_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .tx_done    (tx_done),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .busy       (busy),
        .err        (err),
        .timeout    (timeout),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: A op B, shifts move A right by B.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_NOR:  alu_result = ~(alu_a | alu_b);
            OP_SRA:  alu_result = 8'($signed(alu_a) >>> alu_b[2:0]);
            OP_SRL:  alu_result = alu_a >> alu_b[2:0];
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    // Sends a full frame and checks EXEC/SEND timing; returns with the DUT in WAIT_TX.
    task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [7:0] exp, input logic exp_err);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        check({tag, ".exec_no_start"}, {7'd0, tx_start}, 8'h00);
        tick();
        check({tag, ".start"}, {7'd0, tx_start}, 8'h01);
        check({tag, ".data"}, tx_data, exp);
        check({tag, ".err"}, {7'd0, err}, {7'd0, exp_err});
        tick();
        check({tag, ".start_pulse"}, {7'd0, tx_start}, 8'h00);
        check({tag, ".busy_wait_tx"}, {7'd0, busy}, 8'h01);
    endtask

    task automatic finish_tx(input string tag);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check({tag, ".idle"}, {7'd0, busy}, 8'h00);
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        tx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", {7'd0, busy}, 8'h00);
        check("rst.tx_start", {7'd0, tx_start}, 8'h00);
        check("rst.tx_data", tx_data, 8'h00);
        check("rst.alu_a", alu_a, 8'h00);
        check("rst.alu_op", {2'd0, alu_op}, 8'h00);
        rst_n = 1'b1;

        // ADD, with operand latch checks along the way
        send_byte(8'h35);
        check("add.alu_a", alu_a, 8'h35);
        check("add.busy", {7'd0, busy}, 8'h01);
        send_byte(8'h0A);
        check("add.alu_b", alu_b, 8'h0A);
        send_byte(8'h20);
        check("add.alu_op", {2'd0, alu_op}, 8'h20);
        check("add.exec_no_start", {7'd0, tx_start}, 8'h00);
        tick();
        check("add.start", {7'd0, tx_start}, 8'h01);
        check("add.data", tx_data, 8'h3F);
        tick();
        check("add.start_pulse", {7'd0, tx_start}, 8'h00);
        check("add.data_held", tx_data, 8'h3F);
        finish_tx("add");

        frame("sub", 8'h05, 8'h0A, 8'h22, 8'hFB, 1'b0);
        finish_tx("sub");
        frame("sra", 8'h80, 8'h02, 8'h03, 8'hE0, 1'b0);
        finish_tx("sra");
        frame("bad_op", 8'h12, 8'h34, 8'h3F, 8'hFF, 1'b1);
        tick();
        check("bad_op.err_pulse", {7'd0, err}, 8'h00);
        finish_tx("bad_op");

        // Timeout after 16 idle cycles in WAIT_B
        send_byte(8'h11);
        repeat (15) tick();
        check("to.not_yet", {7'd0, timeout}, 8'h00);
        check("to.busy_before", {7'd0, busy}, 8'h01);
        tick();
        check("to.pulse", {7'd0, timeout}, 8'h01);
        check("to.idle", {7'd0, busy}, 8'h00);
        tick();
        check("to.pulse_end", {7'd0, timeout}, 8'h00);
        frame("after_to", 8'h01, 8'h01, 8'h20, 8'h02, 1'b0);
        finish_tx("after_to");

        // Byte arriving on the expiry cycle is accepted, no timeout
        send_byte(8'h11);
        repeat (15) tick();
        send_byte(8'h22);
        check("race.no_timeout", {7'd0, timeout}, 8'h00);
        check("race.alu_b", alu_b, 8'h22);
        check("race.busy", {7'd0, busy}, 8'h01);
        send_byte(8'h20);
        tick();
        check("race.data", tx_data, 8'h33);
        tick();
        finish_tx("race");

        // Stray TX_DONE outside WAIT_TX must not disturb the frame
        send_byte(8'h07);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("stray_txdone.busy", {7'd0, busy}, 8'h01);
        send_byte(8'h01);
        send_byte(8'h20);
        tick();
        check("stray_txdone.data", tx_data, 8'h08);
        tick();

        // Overrun in WAIT_TX, then coincident with TX_DONE
        send_byte(8'h55);
        check("ovr.pulse", {7'd0, overrun}, 8'h01);
        check("ovr.alu_a_kept", alu_a, 8'h07);
        check("ovr.busy", {7'd0, busy}, 8'h01);
        rx_data = 8'h66;
        rx_done = 1'b1;
        tx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tx_done = 1'b0;
        check("ovr2.pulse", {7'd0, overrun}, 8'h01);
        check("ovr2.alu_a_kept", alu_a, 8'h07);
        check("ovr2.idle", {7'd0, busy}, 8'h00);
        tick();
        check("ovr2.pulse_end", {7'd0, overrun}, 8'h00);

        // Reset during WAIT_OP abandons the frame
        send_byte(8'h0F);
        send_byte(8'h03);
        rst_n = 1'b0;
        #1;
        check("midrst.busy", {7'd0, busy}, 8'h00);
        check("midrst.alu_a", alu_a, 8'h00);
        check("midrst.alu_b", alu_b, 8'h00);
        check("midrst.tx_data", tx_data, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst.no_start", {7'd0, tx_start}, 8'h00);
        end
        frame("post_rst", 8'h0E, 8'h0B, 8'h24, 8'h0A, 1'b0);
        finish_tx("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
